serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 119 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default operand width.
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the only arithmetic element of the serial adder datapath.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: {cout,sum} = a + b + cin, LSB first, one bit per clock via one full adder.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow output ovf.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic [WIDTH-1:0]   a_sh, b_sh, result;
  logic               fa_s, fa_co;
  logic               last_bit;
`ifdef SERIAL_ADDER_OVF_EN
  logic               msb_cin;
`endif

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  full_adder u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control and result registers: cleared by reset, outputs written only in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
      msb_cin <= 1'b0;
`endif
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            carry <= cin;
          end
        end
        SHIFT: begin
          carry <= fa_co;
          cnt   <= cnt + CNT_W'(1);
`ifdef SERIAL_ADDER_OVF_EN
          msb_cin <= carry;
`endif
        end
        DONE: begin
          done <= 1'b1;
          sum  <= result;
          cout <= carry;
`ifdef SERIAL_ADDER_OVF_EN
          ovf  <= msb_cin ^ carry;
`endif
        end
        default: ;
      endcase
    end
  end

  // Operand/result shifters: bit cnt of each operand is always at position 0, and the
  // sum bit enters at the MSB so that after WIDTH shifts bit 0 lands in position 0.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_sh   <= a;
      b_sh   <= b;
      result <= '0;
    end else if (state == SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      result <= {fa_s, result[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8), optional ovf under SERIAL_ADDER_OVF_EN.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, cin;
  logic [7:0] a, b, sum;
  logic       busy, done, cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One operation from IDLE; operands are scrambled after accept, optional start poke in SHIFT.
  task automatic op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                    input logic [7:0] es, input logic ec, input logic eo,
                    input bit poke, input string tag);
    int first_done;
    int pulses;
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~ta; b = ~tb; cin = ~tc;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    first_done = 0;
    pulses     = 0;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (first_done == 0) first_done = n;
      end
      if (poke && n == 3) begin
        start = 1'b1; a = 8'h11; b = 8'h11;
      end
      if (n == 4) start = 1'b0;
    end
    check({tag, "_latency"}, 32'(first_done), 32'd9);
    check({tag, "_pulses"}, 32'(pulses), 32'd1);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`endif
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int d1, d2, pulses;
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0, "add_5a_3c");
    op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "add_ff_01");
    op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, "add_7f_01");
    op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, "add_cin");
    op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1, "poke_shift");

    // start held high: second accept on the edge right after the first done is seen
    a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    d1 = 0; d2 = 0;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk); #1;
      if (done) begin
        if (d1 == 0) begin
          d1 = n;
          check("b2b_sum1", 32'(sum), 32'h07);
          a = 8'h10; b = 8'h20;
        end else if (d2 == 0) begin
          d2 = n;
          check("b2b_sum2", 32'(sum), 32'h30);
        end
      end
      if (n == 10) start = 1'b0;
    end
    check("b2b_done1", 32'(d1), 32'd9);
    check("b2b_done2", 32'(d2), 32'd19);

    // reset in the middle of SHIFT
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("midrst_no_done", 32'(pulses), 32'd0);
    op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
